mdu_seq: RTL and testbench

//  Parametrised iterative multiply/divide unit for the CPU EX stage: signed/unsigned MULT and DIV.

---
 rtl/mdu_pkg.sv | 17 +
 rtl/mdu_sign_fix.sv | 25 ++
 rtl/mdu_seq.sv | 215 +++++++++++++++++++++
 tb/tb_mdu_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings presented on mdu_seq.op
//   - FSM state encoding used by mdu_seq
package mdu_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate.
// Used to take operand magnitudes at start and to restore result signs.
// Ports:
//   val  in   WIDTH  value to condition
//   neg  in   1      1: output -val, 0: output val
//   res  out  WIDTH  conditioned value
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    // Negate when requested, pass through otherwise
    always_comb begin
        res = val;
        if (neg) begin
            res = (~val) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per falling clock
// edge. Results land in hi/lo; busy stalls the pipeline, done pulses once.
// Optional feature macro: MDU_EARLY_OUT_EN (multiply ends as soon as the
// remaining multiplier bits are all zero).
// Ports:
//   clk       in   1      clock, state updates on the falling edge
//   resetn    in   1      synchronous reset, active HIGH despite the name
//   start     in   1      request, sampled only while idle
//   op        in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b      in   WIDTH  multiplicand/dividend, multiplier/divisor
//   busy      out  1      operation in progress
//   done      out  1      one-cycle pulse, hi/lo valid
//   div_zero  out  1      last completed op was a divide by zero
//   hi, lo    out  WIDTH  product high/low, or remainder/quotient
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import mdu_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t               state_r, state_nxt_s;
    logic [CNT_W-1:0]     count_r;
    logic [2*WIDTH-1:0]   acc_r;      // product, or remainder in the upper half
    logic [WIDTH-1:0]     sh_r;       // multiplier, or dividend/quotient
    logic [WIDTH-1:0]     dvs_r;      // multiplicand, or divisor
    logic                 is_div_r, neg_q_r, neg_r_r, b_zero_r;
    logic                 busy_r, done_r, div_zero_r;
    logic [WIDTH-1:0]     hi_r, lo_r;

    logic                 sign_a_s, sign_b_s;
    logic [WIDTH-1:0]     abs_a_s, abs_b_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_acc_nxt_s;
    logic [WIDTH:0]       div_rem_sh_s;
    logic                 div_ge_s;
    logic [WIDTH-1:0]     div_rem_nxt_s;
    logic                 early_s;
    logic [2*WIDTH-1:0]   prod_s, prod_fix_s;
    logic [WIDTH-1:0]     quo_fix_s, rem_fix_s;
    logic [WIDTH-1:0]     hi_res_s, lo_res_s;

    assign sign_a_s = op[0] & a[WIDTH-1];
    assign sign_b_s = op[0] & b[WIDTH-1];

    // MIN maps to 2^(W-1), which is exact in unsigned W-bit arithmetic
    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.val(a), .neg(sign_a_s), .res(abs_a_s));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.val(b), .neg(sign_b_s), .res(abs_b_s));

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                      + (sh_r[0] ? {1'b0, dvs_r} : {(WIDTH+1){1'b0}});
        mul_acc_nxt_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        div_rem_sh_s  = {acc_r[2*WIDTH-1:WIDTH], sh_r[WIDTH-1]};
        div_ge_s      = (div_rem_sh_s >= {1'b0, dvs_r});
        // When div_ge_s holds the true difference is below the divisor, so W bits suffice
        div_rem_nxt_s = div_ge_s ? (div_rem_sh_s[WIDTH-1:0] - dvs_r) : div_rem_sh_s[WIDTH-1:0];
    end

`ifdef MDU_EARLY_OUT_EN
    localparam logic [CNT_W:0] W_CNT = (CNT_W+1)'(WIDTH);
    logic [CNT_W:0] shift_s;

    // Early exit leaves the partial product W-k places high; count_r holds k
    always_comb begin
        early_s = (!is_div_r) && (sh_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
        if (count_r == {CNT_W{1'b0}}) begin
            shift_s = {(CNT_W+1){1'b0}};
        end else begin
            shift_s = W_CNT - {1'b0, count_r};
        end
        prod_s = acc_r >> shift_s;
    end
`else
    // Fixed latency: the product is fully aligned after WIDTH steps
    always_comb begin
        early_s = 1'b0;
        prod_s  = acc_r;
    end
`endif

    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.val(prod_s), .neg(neg_q_r), .res(prod_fix_s));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.val(sh_r), .neg(neg_q_r), .res(quo_fix_s));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.val(acc_r[2*WIDTH-1:WIDTH]), .neg(neg_r_r), .res(rem_fix_s));

    // Final hi/lo selection; divide by zero forces an all-ones quotient
    always_comb begin
        hi_res_s = prod_fix_s[2*WIDTH-1:WIDTH];
        lo_res_s = prod_fix_s[WIDTH-1:0];
        if (is_div_r) begin
            hi_res_s = rem_fix_s;
            if (b_zero_r) begin
                lo_res_s = {WIDTH{1'b1}};
            end else begin
                lo_res_s = quo_fix_s;
            end
        end else begin
            hi_res_s = prod_fix_s[2*WIDTH-1:WIDTH];
            lo_res_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // FSM state register
    always_ff @(negedge clk) begin
        if (resetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_CALC;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CALC: begin
                if ((count_r == CNT_LAST) || early_s) begin
                    state_nxt_s = S_FIX;
                end else begin
                    state_nxt_s = S_CALC;
                end
            end
            S_FIX:   state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Datapath and output registers
    always_ff @(negedge clk) begin
        if (resetn) begin
            count_r    <= {CNT_W{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            sh_r       <= {WIDTH{1'b0}};
            dvs_r      <= {WIDTH{1'b0}};
            is_div_r   <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            b_zero_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        is_div_r <= op[1];
                        neg_q_r  <= sign_a_s ^ sign_b_s;
                        neg_r_r  <= sign_a_s;
                        b_zero_r <= (b == {WIDTH{1'b0}});
                        count_r  <= {CNT_W{1'b0}};
                        acc_r    <= {(2*WIDTH){1'b0}};
                        // Divide shifts the dividend; multiply shifts the multiplier
                        sh_r     <= op[1] ? abs_a_s : abs_b_s;
                        dvs_r    <= op[1] ? abs_b_s : abs_a_s;
                        busy_r   <= 1'b1;
                    end else begin
                        busy_r   <= 1'b0;
                    end
                end
                S_CALC: begin
                    count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (is_div_r) begin
                        acc_r <= {div_rem_nxt_s, {WIDTH{1'b0}}};
                        sh_r  <= {sh_r[WIDTH-2:0], div_ge_s};
                    end else begin
                        acc_r <= mul_acc_nxt_s;
                        sh_r  <= {1'b0, sh_r[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    hi_r       <= hi_res_s;
                    lo_r       <= lo_res_s;
                    div_zero_r <= is_div_r & b_zero_r;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq (WIDTH=32): directed vectors with fixed
// expected values, reference-model vectors, ignored-start and mid-op reset.
module tb_mdu_seq;
    localparam int W = 32;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    typedef struct {
        string        tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    mdu_seq #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: plain wide arithmetic
    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] h, output logic [W-1:0] l, output logic d);
        longint      sx, sy, p, q, r;
        logic [63:0] up;
        d = 1'b0;
        h = '0;
        l = '0;
        case (o)
            2'b00: begin
                up = {32'h0, x} * {32'h0, y};
                h = up[63:32]; l = up[31:0];
            end
            2'b01: begin
                sx = longint'($signed(x)); sy = longint'($signed(y));
                p = sx * sy;
                h = p[63:32]; l = p[31:0];
            end
            default: begin
                if (y == 32'h0) begin
                    h = x; l = 32'hFFFF_FFFF; d = 1'b1;
                end else if (o == 2'b10) begin
                    l = x / y; h = x % y;
                end else begin
                    sx = longint'($signed(x)); sy = longint'($signed(y));
                    q = sx / sy; r = sx % sy;
                    l = q[31:0]; h = r[31:0];
                end
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] y);
        int k;
        logic [W-1:0] mag;
        k = W;
        mag = (o[0] && y[W-1]) ? (~y + 32'd1) : y;
`ifdef MDU_EARLY_OUT_EN
        if (!o[1]) begin
            k = 1;
            for (int i = 0; i < W; i++) if (mag[i]) k = i + 1;
        end
`endif
        return k + 1;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed, input int poke);
        exp_t e, g;
        int   nb;
        bit   got;
        e.tag = tag; e.hi = eh; e.lo = el; e.dz = ed; e.lat = exp_lat(o, y);
        sb_q.push_back(e);
        @(posedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        nb = 0; got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            if (busy) nb++;
            if (poke > 0 && busy && nb == poke) begin
                start = 1'b1; op = 2'b10; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                if (sb_q.size() == 0) begin
                    check_val({tag, "_sb_underflow"}, 64'd1, 64'd0);
                end else begin
                    g = sb_q.pop_front();
                    check_val({g.tag, "_hi"}, 64'(hi), 64'(g.hi));
                    check_val({g.tag, "_lo"}, 64'(lo), 64'(g.lo));
                    check_val({g.tag, "_dz"}, 64'(div_zero), 64'(g.dz));
                    check_val({g.tag, "_busy_cycles"}, 64'(nb), 64'(g.lat));
                    check_val({g.tag, "_busy_at_done"}, 64'(busy), 64'd0);
                end
            end else begin
                @(posedge clk);
            end
        end
        if (!got) begin
            check_val({tag, "_timeout"}, 64'd0, 64'd1);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end else begin
            @(posedge clk);
            check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] rx, ry, mh, ml;
        logic         md;

        resetn = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_dz", 64'(div_zero), 64'd0);
        check_val("rst_hi", 64'(hi), 64'd0);
        check_val("rst_lo", 64'(lo), 64'd0);
        resetn = 1'b0;

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
        run_op("mult_neg3x7", 2'b01, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
        run_op("mult_minxmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);
        run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 0);
        run_op("multu_poke", 2'b00, 32'h0000_1234, 32'h0000_5678, 32'h0, 32'h0626_0060, 1'b0, 5);
        run_op("divu_by0", 2'b10, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, 0);
        run_op("div_by0", 2'b11, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 0);

        // Reset in the middle of a divide
        @(posedge clk);
        start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        check_val("midrst_busy_before", 64'(busy), 64'd1);
        resetn = 1'b1;
        @(posedge clk);
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_done", 64'(done), 64'd0);
        check_val("midrst_dz", 64'(div_zero), 64'd0);
        check_val("midrst_hi", 64'(hi), 64'd0);
        check_val("midrst_lo", 64'(lo), 64'd0);
        resetn = 1'b0;
        run_op("multu_6x7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 0);

        run_op("multu_5x3", 2'b00, 32'd5, 32'd3, 32'd0, 32'd15, 1'b0, 0);
        run_op("multu_x0", 2'b00, 32'h0000_ABCD, 32'd0, 32'd0, 32'd0, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom);
            rx = $urandom;
            ry = (i % 5 == 4) ? 32'($urandom_range(0, 9)) : $urandom;
            model(ro, rx, ry, mh, ml, md);
            run_op("rand", ro, rx, ry, mh, ml, md, 0);
        end

        check_val("sb_leftover", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
